// File: rtl/ising_axi.sv
// Ising-machine annealer behind a simple AXI-style register interface.
// Round-robin spin updates driven by programmable symmetric couplings, with per-spin phase counters.
module ising_axi #(
    parameter int unsigned N           = 8,
    parameter int unsigned NUM_WEIGHTS = 3,
    parameter int          WIRE_DELAY  = 10
) (
    input  logic        clk,
    input  logic        axi_rst,
    input  logic        arvalid_q,
    input  logic [31:0] araddr_q,
    input  logic        rready,
    output logic        rvalid,
    output logic [1:0]  rresp,
    output logic [31:0] rdata,
    input  logic        wready,
    input  logic [31:0] wr_addr,
    input  logic [31:0] wdata
);

    localparam int unsigned IW   = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned HW   = $clog2(N * (2 ** NUM_WEIGHTS)) + 2;
    localparam int unsigned VOFF = 2 ** (NUM_WEIGHTS - 2);
    localparam logic [31:0] START_ADDR      = 32'h0000_0000;
    localparam logic [31:0] CTR_CUTOFF_ADDR = 32'h0000_0004;
    localparam logic [31:0] CTR_MAX_ADDR    = 32'h0000_0008;
    localparam logic [31:0] PHASE_ADDR_BASE = 32'h0000_0100;

    if (NUM_WEIGHTS < 2 || WIRE_DELAY < 0) begin : g_param_check
        $error("ising_axi: NUM_WEIGHTS must be >= 2 and WIRE_DELAY non-negative");
    end

    logic [NUM_WEIGHTS-1:0] r_j [N][N];
    logic [N-1:0]           r_init;
    logic [N-1:0]           r_spin;
    logic [31:0]            r_ctr [N];
    logic [31:0]            r_cutoff;
    logic [31:0]            r_max;
    logic                   r_run;
    logic [IW-1:0]          r_idx;
    logic                   r_rvalid;
    logic [31:0]            r_rdata;

    logic                   w_wr_wt;
    logic [IW-1:0]          w_wi;
    logic [IW-1:0]          w_wj;
    logic                   w_rd_wt;
    logic                   w_rd_ph;
    logic [IW-1:0]          w_ri;
    logic [IW-1:0]          w_rj;
    logic [31:0]            w_rk;
    logic [31:0]            w_rd_data;
    logic signed [HW-1:0]   w_term;
    logic signed [HW-1:0]   w_h;

    // Weight window: i in addr[12:2], j in addr[19:13]; out-of-range indices fall through to 0.
    assign w_wi    = IW'(wr_addr[12:2]);
    assign w_wj    = IW'(wr_addr[19:13]);
    assign w_wr_wt = wready && (wr_addr[31:20] == 12'h001) && (wr_addr[1:0] == 2'b00)
                     && (32'(wr_addr[12:2]) < N) && (32'(wr_addr[19:13]) < N);
    assign w_ri    = IW'(araddr_q[12:2]);
    assign w_rj    = IW'(araddr_q[19:13]);
    assign w_rd_wt = (araddr_q[31:20] == 12'h001) && (araddr_q[1:0] == 2'b00)
                     && (32'(araddr_q[12:2]) < N) && (32'(araddr_q[19:13]) < N);
    assign w_rk    = (araddr_q - PHASE_ADDR_BASE) >> 2;
    assign w_rd_ph = (araddr_q >= PHASE_ADDR_BASE) && (araddr_q[1:0] == 2'b00) && (w_rk < N);

    always_comb begin
        w_rd_data = '0;
        if (araddr_q == CTR_CUTOFF_ADDR) begin
            w_rd_data = r_cutoff;
        end else if (araddr_q == CTR_MAX_ADDR) begin
            w_rd_data = r_max;
        end else if (w_rd_ph) begin
            w_rd_data = r_ctr[IW'(N - 1 - w_rk)];
        end else if (w_rd_wt) begin
            w_rd_data = (w_ri == w_rj) ? 32'(r_init[w_ri]) : 32'(r_j[w_ri][w_rj]);
        end
    end

    // Local field of the spin selected by the round-robin index.
    always_comb begin
        w_h    = '0;
        w_term = '0;
        for (int unsigned j = 0; j < N; j++) begin
            w_term = $signed(HW'(r_j[r_idx][IW'(j)])) - $signed(HW'(VOFF));
            if (IW'(j) != r_idx) begin
                w_h = r_spin[IW'(j)] ? (w_h + w_term) : (w_h - w_term);
            end
        end
    end

    always_ff @(posedge clk or posedge axi_rst) begin
        if (axi_rst) begin
            for (int unsigned a = 0; a < N; a++) begin
                for (int unsigned b = 0; b < N; b++) begin
                    r_j[IW'(a)][IW'(b)] <= NUM_WEIGHTS'(VOFF);
                end
                r_ctr[IW'(a)] <= 32'd4;
            end
            r_init   <= '0;
            r_spin   <= N'(1) << (N - 1);
            r_cutoff <= 32'd4;
            r_max    <= 32'd8;
            r_run    <= 1'b0;
            r_idx    <= '0;
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
        end else begin
            if (r_run) begin
                r_idx <= (r_idx == IW'(N - 2)) ? '0 : r_idx + IW'(1);
                if (w_h[HW-1]) begin
                    r_spin[r_idx] <= 1'b0;
                end else if (w_h != '0) begin
                    r_spin[r_idx] <= 1'b1;
                end
                // Counters track agreement with the reference spin, saturating in [0, CTR_MAX].
                for (int unsigned k = 0; k < N; k++) begin
                    if (r_ctr[IW'(k)] > r_max) begin
                        r_ctr[IW'(k)] <= r_max;
                    end else if (r_spin[IW'(k)] == r_spin[N-1]) begin
                        if (r_ctr[IW'(k)] != r_max) r_ctr[IW'(k)] <= r_ctr[IW'(k)] + 32'd1;
                    end else if (r_ctr[IW'(k)] != 32'd0) begin
                        r_ctr[IW'(k)] <= r_ctr[IW'(k)] - 32'd1;
                    end
                end
            end
            if (w_wr_wt) begin
                if (w_wi == w_wj) begin
                    r_init[w_wi] <= wdata[0];
                end else begin
                    r_j[w_wi][w_wj] <= wdata[NUM_WEIGHTS-1:0];
                    r_j[w_wj][w_wi] <= wdata[NUM_WEIGHTS-1:0];
                end
            end
            if (wready && wr_addr == CTR_CUTOFF_ADDR) r_cutoff <= wdata;
            if (wready && wr_addr == CTR_MAX_ADDR)    r_max    <= wdata;
            if (wready && wr_addr == START_ADDR) begin
                if (wdata[8]) begin
                    for (int unsigned k = 0; k < N; k++) begin
                        r_spin[IW'(k)] <= (k == N - 1) ? 1'b1 : r_init[IW'(k)];
                        r_ctr[IW'(k)]  <= r_cutoff;
                    end
                    r_run <= 1'b1;
                    r_idx <= '0;
                end else begin
                    r_run <= wdata[4];
                end
            end
            if (arvalid_q) begin
                r_rvalid <= 1'b1;
                r_rdata  <= w_rd_data;
            end else if (rready) begin
                r_rvalid <= 1'b0;
            end
        end
    end

    assign rvalid = r_rvalid;
    assign rdata  = r_rdata;
    assign rresp  = 2'b00;

endmodule

// File: tb/tb_ising_axi.sv
// Directed, table-driven bench for ising_axi: register map, read timing and annealing scenarios.
module tb_ising_axi;

    logic        clk = 1'b0;
    logic        axi_rst = 1'b1;
    logic        arvalid_q = 1'b0;
    logic [31:0] araddr_q = '0;
    logic        rready = 1'b1;
    logic        rvalid;
    logic [1:0]  rresp;
    logic [31:0] rdata;
    logic        wready = 1'b0;
    logic [31:0] wr_addr = '0;
    logic [31:0] wdata = '0;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit          is_wr;
        logic [31:0] addr;
        logic [31:0] data;
    } vec_t;
    vec_t tbl[$];

    ising_axi #(.N(8), .NUM_WEIGHTS(3), .WIRE_DELAY(10)) dut (
        .clk(clk), .axi_rst(axi_rst), .arvalid_q(arvalid_q), .araddr_q(araddr_q),
        .rready(rready), .rvalid(rvalid), .rresp(rresp), .rdata(rdata),
        .wready(wready), .wr_addr(wr_addr), .wdata(wdata)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    function automatic logic [31:0] waddr(input int unsigned i, input int unsigned j);
        return 32'h0010_0000 + 32'(i << 2) + 32'(j << 13);
    endfunction

    function automatic logic [31:0] paddr(input int unsigned k);
        return 32'h0000_0100 + 32'(k << 2);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        wready = 1'b1; wr_addr = a; wdata = d;
        @(posedge clk);
        #1 wready = 1'b0;
    endtask

    task automatic rd_chk(input string name, input logic [31:0] a, input logic [31:0] exp);
        @(negedge clk);
        arvalid_q = 1'b1; araddr_q = a;
        @(posedge clk);
        #1;
        chk(name, rdata, exp);
        chk({name, "_rvalid"}, 32'(rvalid), 32'd1);
        arvalid_q = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk) axi_rst = 1'b1;
        @(negedge clk) axi_rst = 1'b0;
    endtask

    task automatic program_maxcut();
        wr(waddr(0, 1), 1); wr(waddr(0, 4), 1); wr(waddr(1, 2), 1);
        wr(waddr(1, 3), 1); wr(waddr(2, 3), 1); wr(waddr(3, 4), 1);
        for (int unsigned k = 0; k < 5; k++) wr(waddr(k, 7), 4);
        wr(32'h4, 4);
        wr(32'h8, 8);
    endtask

    task automatic chk_maxcut(input string tag);
        logic [31:0] exp_ph [8];
        exp_ph = '{8, 0, 0, 0, 8, 8, 0, 8};
        for (int unsigned k = 0; k < 8; k++)
            rd_chk($sformatf("%s_ph%0d", tag, k), paddr(k), exp_ph[k]);
    endtask

    initial begin
        logic [31:0] exp_v;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rvalid", 32'(rvalid), 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_rresp", 32'(rresp), 32'd0);
        @(negedge clk) axi_rst = 1'b0;

        // Register map vectors: {write?, address, write data / expected read data}.
        tbl.push_back('{1'b0, waddr(0, 1), 32'h2});
        tbl.push_back('{1'b0, paddr(0), 32'h4});
        tbl.push_back('{1'b0, 32'h8, 32'h8});
        tbl.push_back('{1'b0, 32'h4, 32'h4});
        tbl.push_back('{1'b0, paddr(7), 32'h4});
        tbl.push_back('{1'b0, waddr(2, 2), 32'h0});
        tbl.push_back('{1'b0, 32'hC, 32'h0});
        tbl.push_back('{1'b0, paddr(8), 32'h0});
        tbl.push_back('{1'b0, waddr(8, 0), 32'h0});
        tbl.push_back('{1'b1, waddr(0, 1), 32'h1});
        tbl.push_back('{1'b0, waddr(0, 1), 32'h1});
        tbl.push_back('{1'b0, waddr(1, 0), 32'h1});
        tbl.push_back('{1'b1, waddr(2, 2), 32'h1});
        tbl.push_back('{1'b0, waddr(2, 2), 32'h1});
        tbl.push_back('{1'b1, waddr(3, 5), 32'hFFFF_FFF5});
        tbl.push_back('{1'b0, waddr(5, 3), 32'h5});
        tbl.push_back('{1'b1, waddr(6, 9), 32'h7});
        tbl.push_back('{1'b0, waddr(6, 9), 32'h0});
        tbl.push_back('{1'b0, waddr(6, 7), 32'h2});
        tbl.push_back('{1'b1, 32'h8, 32'h1234_5678});
        tbl.push_back('{1'b0, 32'h8, 32'h1234_5678});
        tbl.push_back('{1'b1, 32'h4, 32'h0000_ABCD});
        tbl.push_back('{1'b0, 32'h4, 32'h0000_ABCD});
        tbl.push_back('{1'b1, 32'h200, 32'hFF});
        tbl.push_back('{1'b0, 32'h200, 32'h0});
        foreach (tbl[i]) begin
            if (tbl[i].is_wr) wr(tbl[i].addr, tbl[i].data);
            else rd_chk($sformatf("vec%0d", i), tbl[i].addr, tbl[i].data);
        end

        // Same-edge read and write of one register returns the old value.
        @(negedge clk);
        arvalid_q = 1'b1; araddr_q = 32'h4;
        wready = 1'b1; wr_addr = 32'h4; wdata = 32'h55;
        @(posedge clk);
        #1;
        chk("rw_same_old", rdata, 32'h0000_ABCD);
        arvalid_q = 1'b0; wready = 1'b0;
        rd_chk("rw_same_new", 32'h4, 32'h55);

        // rvalid holds until accepted.
        rready = 1'b0;
        rd_chk("hold_rd", 32'h8, 32'h1234_5678);
        @(posedge clk); #1;
        chk("hold_rvalid", 32'(rvalid), 32'd1);
        rready = 1'b1;
        @(posedge clk); #1;
        chk("clear_rvalid", 32'(rvalid), 32'd0);

        // Restart then stop on the next edge: exactly one running cycle.
        do_reset();
        program_maxcut();
        wr(32'h0, 32'h100);
        wr(32'h0, 32'h0);
        for (int unsigned k = 0; k < 8; k++)
            rd_chk($sformatf("frz1_ph%0d", k), paddr(k), (k == 0) ? 32'd5 : 32'd3);
        repeat (50) @(posedge clk);
        for (int unsigned k = 0; k < 8; k++)
            rd_chk($sformatf("frz2_ph%0d", k), paddr(k), (k == 0) ? 32'd5 : 32'd3);

        // Resume for one cycle: index and spin 0 were held across the stop.
        wr(32'h0, 32'h10);
        wr(32'h0, 32'h0);
        for (int unsigned k = 0; k < 8; k++) begin
            exp_v = (k == 0) ? 32'd6 : ((k == 7) ? 32'd4 : 32'd2);
            rd_chk($sformatf("res_ph%0d", k), paddr(k), exp_v);
        end

        wr(32'h0, 32'h10);
        repeat (100) @(posedge clk);
        chk_maxcut("run");

        wr(32'h0, 32'h110);
        repeat (100) @(posedge clk);
        chk_maxcut("restart");

        // Reset while running wipes everything immediately.
        rd_chk("pre_rst", 32'h8, 32'h8);
        @(negedge clk) axi_rst = 1'b1;
        #1;
        chk("midrst_rvalid", 32'(rvalid), 32'd0);
        chk("midrst_rdata", rdata, 32'd0);
        @(negedge clk) axi_rst = 1'b0;
        repeat (10) @(posedge clk);
        rd_chk("post_w01", waddr(0, 1), 32'h2);
        rd_chk("post_w47", waddr(4, 7), 32'h2);
        rd_chk("post_ph0", paddr(0), 32'h4);
        rd_chk("post_ph4", paddr(4), 32'h4);
        rd_chk("post_max", 32'h8, 32'h8);
        rd_chk("post_cut", 32'h4, 32'h4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
